if_of_pipe_buffer: RTL
======================

// Module: if_of_pipe_buffer
// PURPOSE
//  Parametrised IF->OF pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Holds on data interlock; kills the in-flight contents on a branch interlock and injects a NOP bubble.
//  Keeps saturating stall/flush event counters for performance debug.
//  Sits between the fetch stage and operand-fetch; next generation of the IF/OF latch.
// PARAMETERS
//  PC_W        32            width of PC field
//  INSTR_W     32            width of instruction field
//  NOP_INSTR   32'h68000000  instruction value injected as bubble (ISA nop)
//  RESET_PC    0             PC value presented on out_pc after reset and in bubbles
//  BUBBLE_ON_FLUSH 1         1: flush leaves one valid NOP bubble; 0: flush leaves stage empty
//  CNT_W       16            width of stall/flush counters (saturating)
// PORTS
//  clk           in   1        clock; all state updates on falling edge (negedge clk)
//  rst_n         in   1        synchronous active-low reset, sampled on negedge clk
//  in_valid      in   1        IF presents a fetched instruction
//  in_ready      out  1        buffer accepts this cycle (combinational)
//  in_pc         in   PC_W     PC of fetched instruction
//  in_instr      in   INSTR_W  fetched instruction
//  stall         in   1        data interlock: block new input, hold contents
//  flush         in   1        branch interlock: discard contents and input
//  out_valid     out  1        out_pc/out_instr valid for OF
//  out_ready     in   1        OF consumes head entry this cycle
//  out_pc        out  PC_W     head entry PC
//  out_instr     out  INSTR_W  head entry instruction
//  out_bubble    out  1        head entry is an injected NOP
//  stall_cnt     out  CNT_W    cycles with stall=1 (saturating)
//  flush_cnt     out  CNT_W    cycles with flush=1 (saturating)
// BEHAVIOUR
//  Reset (rst_n=0 at negedge): state EMPTY, out_valid=0, out_bubble=0, out_pc=RESET_PC,
//   out_instr=NOP_INSTR, skid entry cleared, stall_cnt=flush_cnt=0. Reset beats flush and stall.
//  States: EMPTY (no entries), ONE (head only), TWO (head + skid). Head drives outputs directly.
//  in_ready = rst_n & ~flush & ~stall & (state != TWO). Latency in->out: 1 edge when EMPTY.
//  push = in_valid & in_ready; pop = out_valid & out_ready (pop unaffected by stall).
//  EMPTY: push -> ONE (head<=input).
//  ONE: push&~pop -> TWO (skid<=input); push&pop -> ONE (head<=input); pop&~push -> EMPTY.
//  TWO: pop -> ONE (head<=skid); no push possible.
//  Order preserved: skid entry is always younger than head.
//  stall=1: no push; head/skid held unless popped; out_valid unchanged.
//  flush=1 (priority over stall and push): skid cleared; input dropped; pop ignored.
//   BUBBLE_ON_FLUSH=1 -> ONE with head={RESET_PC,NOP_INSTR}, out_bubble=1.
//   BUBBLE_ON_FLUSH=0 -> EMPTY, out_valid=0.
//  out_bubble=0 on every head load from input or skid.
//  Bubble entries pop like normal entries.
//  Counters: +1 per cycle of their input, saturate at all-ones, never wrap; both may count same cycle.
//  Holding: when EMPTY, out_pc/out_instr keep last head value (not X).
// STRUCTURE
//  Shared package pipe_pkg: state enum {EMPTY,ONE,TWO}, ISA_NOP=32'h68000000 constant.
//  One sub-module: sat_counter (CNT_W, inc, rst_n) instantiated twice.
//  Head/skid registers and state FSM in this module; no memories.
// TESTING
//  Reset then in_valid=1, pc=0x4, instr=0x12345678, out_ready=1 -> next edge out_valid=1, out_pc=0x4.
//  out_ready=0, push pc=0x8 then 0xC -> state TWO, in_ready=0; out_ready=1 -> outputs 0x8 then 0xC in order.
//  stall=1 for 3 cycles with in_valid=1 -> no push, head held, stall_cnt=3.
//  State TWO, flush=1 with in_valid=1 -> next edge out_instr=0x68000000, out_pc=0, out_bubble=1, skid empty, flush_cnt=1.
//  flush=1 and stall=1 same cycle -> flush behaviour wins, both counters increment.
//  rst_n=0 mid-TWO -> out_valid=0, counters 0; stall held 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/OF pipeline buffer.
// Provides the occupancy state encoding and the ISA nop word.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [31:0] ISA_NOP = 32'h68000000;

  function automatic logic has_room(input state_e s);
    return (s != TWO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter that updates on the falling clock edge.
// Increments once per cycle while inc is high and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  // Count events, holding at the maximum value instead of wrapping.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (inc && !w_at_max) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/if_of_pipe_buffer.sv
// IF->OF pipeline register with a head entry plus one skid entry.
// Stall holds contents, flush kills them and may inject a NOP bubble.
module if_of_pipe_buffer
  import pipe_pkg::*;
#(
  parameter int                 PC_W            = 32,
  parameter int                 INSTR_W         = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR       = ISA_NOP,
  parameter logic [PC_W-1:0]    RESET_PC        = {PC_W{1'b0}},
  parameter bit                 BUBBLE_ON_FLUSH = 1'b1,
  parameter int                 CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  state_e             r_state;
  logic [PC_W-1:0]    r_head_pc;
  logic [INSTR_W-1:0] r_head_instr;
  logic               r_head_bubble;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;

  logic w_push;
  logic w_pop;

  assign in_ready  = rst_n & ~flush & ~stall & has_room(r_state);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Occupancy FSM with head/skid loads; flush outranks stall, push and pop.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_state       <= EMPTY;
      r_head_pc     <= RESET_PC;
      r_head_instr  <= NOP_INSTR;
      r_head_bubble <= 1'b0;
      r_skid_pc     <= RESET_PC;
      r_skid_instr  <= NOP_INSTR;
    end else if (flush) begin
      r_skid_pc    <= RESET_PC;
      r_skid_instr <= NOP_INSTR;
      if (BUBBLE_ON_FLUSH) begin
        r_state       <= ONE;
        r_head_pc     <= RESET_PC;
        r_head_instr  <= NOP_INSTR;
        r_head_bubble <= 1'b1;
      end else begin
        r_state       <= EMPTY;
        r_head_bubble <= 1'b0;
      end
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state       <= ONE;
            r_head_pc     <= in_pc;
            r_head_instr  <= in_instr;
            r_head_bubble <= 1'b0;
          end else begin
            r_state <= EMPTY;
          end
        end
        ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_state      <= TWO;
              r_skid_pc    <= in_pc;
              r_skid_instr <= in_instr;
            end
            2'b11: begin
              r_head_pc     <= in_pc;
              r_head_instr  <= in_instr;
              r_head_bubble <= 1'b0;
            end
            2'b01: begin
              r_state       <= EMPTY;
              r_head_bubble <= 1'b0;
            end
            default: begin
              r_state <= ONE;
            end
          endcase
        end
        TWO: begin
          if (w_pop) begin
            r_state       <= ONE;
            r_head_pc     <= r_skid_pc;
            r_head_instr  <= r_skid_instr;
            r_head_bubble <= 1'b0;
            r_skid_pc     <= RESET_PC;
            r_skid_instr  <= NOP_INSTR;
          end else begin
            r_state <= TWO;
          end
        end
        default: begin
          r_state       <= EMPTY;
          r_head_bubble <= 1'b0;
        end
      endcase
    end
  end

  assign out_pc     = r_head_pc;
  assign out_instr  = r_head_instr;
  assign out_bubble = r_head_bubble;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .cnt   (flush_cnt)
  );

endmodule
